// File: rtl/key_codes_pkg.sv
// Shared PS/2 set-2 scan-code constants, the caps state encoding and the letter table
// used by key_event_filter and letter_lut.
package key_codes_pkg;

    localparam logic [8:0] CAPS_CODE_DEF   = 9'h058;
    localparam logic [8:0] LSHIFT_CODE_DEF = 9'h012;
    localparam logic [8:0] RSHIFT_CODE_DEF = 9'h059;

    localparam int         NUM_LETTERS = 26;
    localparam logic [4:0] LETTER_NONE = 5'd0;

    // Index gi holds the make code of letter 'a'+gi (z is listed first, a last).
    localparam logic [NUM_LETTERS-1:0][7:0] LETTER_CODES = {
        8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D, 8'h15,
        8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43, 8'h33, 8'h34,
        8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
    };

    typedef enum logic {
        CAPS_UP   = 1'b0,
        CAPS_DOWN = 1'b1
    } caps_state_t;

endpackage

// File: rtl/key_event_filter_letter_lut.sv
// Combinational map from a 9-bit scan code to {is_letter, idx}; E0-extended codes never match.
module letter_lut
    import key_codes_pkg::*;
(
    input  logic [8:0] code,
    output logic       is_letter,
    output logic [4:0] idx
);

    logic [NUM_LETTERS-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LETTERS; gi++) begin : g_cmp
            assign hit[gi] = (code[8] == 1'b0) && (code[7:0] == LETTER_CODES[gi]);
        end
    endgenerate

    // Codes in the table are unique, so at most one hit bit is set.
    always_comb begin
        is_letter = |hit;
        idx       = LETTER_NONE;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (hit[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/key_event_filter.sv
// Turns raw PS/2 make/break events into caps/letter pulses and a shift level.
// Build option: define LETTER_REPEAT_EN to let typematic repeats of the held letter pulse again.
module key_event_filter
    import key_codes_pkg::*;
#(
    parameter logic [8:0] CAPS_CODE   = CAPS_CODE_DEF,
    parameter logic [8:0] LSHIFT_CODE = LSHIFT_CODE_DEF,
    parameter logic [8:0] RSHIFT_CODE = RSHIFT_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_make,
    output logic       caps_valid,
    output logic       letter_valid,
    output logic [4:0] letter_idx,
    output logic       shift_held
);

    caps_state_t state_reg, state_next;
    logic        caps_valid_reg, caps_valid_next;
    logic        letter_valid_reg, letter_valid_next;
    logic [4:0]  letter_idx_reg, letter_idx_next;
    logic        lshift_dn_reg, lshift_dn_next;
    logic        rshift_dn_reg, rshift_dn_next;
    logic        shift_held_reg;
    logic [7:0]  held_code_reg, held_code_next;
    logic        held_vld_reg, held_vld_next;

    logic        lut_is_letter;
    logic [4:0]  lut_idx;

    letter_lut u_letter_lut (
        .code      (key_code),
        .is_letter (lut_is_letter),
        .idx       (lut_idx)
    );

    // Caps Lock FSM: only the UP->DOWN transition produces a pulse.
    always_comb begin
        state_next      = state_reg;
        caps_valid_next = 1'b0;
        if (key_valid && key_code == CAPS_CODE) begin
            if (key_make) begin
                if (state_reg == CAPS_UP) caps_valid_next = 1'b1;
                state_next = CAPS_DOWN;
            end else begin
                state_next = CAPS_UP;
            end
        end
    end

    always_comb begin
        lshift_dn_next = lshift_dn_reg;
        rshift_dn_next = rshift_dn_reg;
        if (key_valid && key_code == LSHIFT_CODE) lshift_dn_next = key_make;
        if (key_valid && key_code == RSHIFT_CODE) rshift_dn_next = key_make;
    end

    always_comb begin
        letter_valid_next = 1'b0;
        letter_idx_next   = letter_idx_reg;
        held_code_next    = held_code_reg;
        held_vld_next     = held_vld_reg;
        if (key_valid && lut_is_letter) begin
            if (key_make) begin
                if (held_vld_reg && held_code_reg == key_code[7:0]) begin
`ifdef LETTER_REPEAT_EN
                    letter_valid_next = 1'b1;
`else
                    letter_valid_next = 1'b0;
`endif
                end else begin
                    letter_valid_next = 1'b1;
                    letter_idx_next   = lut_idx;
                    held_code_next    = key_code[7:0];
                    held_vld_next     = 1'b1;
                end
            end else if (held_vld_reg && held_code_reg == key_code[7:0]) begin
                held_vld_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= CAPS_UP;
            caps_valid_reg   <= 1'b0;
            letter_valid_reg <= 1'b0;
            letter_idx_reg   <= LETTER_NONE;
            lshift_dn_reg    <= 1'b0;
            rshift_dn_reg    <= 1'b0;
            shift_held_reg   <= 1'b0;
            held_code_reg    <= 8'h00;
            held_vld_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            caps_valid_reg   <= caps_valid_next;
            letter_valid_reg <= letter_valid_next;
            letter_idx_reg   <= letter_idx_next;
            lshift_dn_reg    <= lshift_dn_next;
            rshift_dn_reg    <= rshift_dn_next;
            // Built from the next values so the level follows the event by one cycle.
            shift_held_reg   <= lshift_dn_next | rshift_dn_next;
            held_code_reg    <= held_code_next;
            held_vld_reg     <= held_vld_next;
        end
    end

    assign caps_valid   = caps_valid_reg;
    assign letter_valid = letter_valid_reg;
    assign letter_idx   = letter_idx_reg;
    assign shift_held   = shift_held_reg;

endmodule

// File: tb/tb_key_event_filter.sv
// Self-checking bench for key_event_filter: table of events with expected next-cycle outputs,
// run through a scoreboard queue, plus hand-written async-reset sequences.
module tb_key_event_filter;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [8:0] key_code;
    logic       key_make;
    logic       caps_valid;
    logic       letter_valid;
    logic [4:0] letter_idx;
    logic       shift_held;

    key_event_filter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_make     (key_make),
        .caps_valid   (caps_valid),
        .letter_valid (letter_valid),
        .letter_idx   (letter_idx),
        .shift_held   (shift_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LETTER_REPEAT_EN
    localparam logic REP = 1'b1;
`else
    localparam logic REP = 1'b0;
`endif

    typedef struct {
        logic       valid;
        logic [8:0] code;
        logic       make;
        logic       caps;
        logic       letter;
        logic [4:0] idx;
        logic       shift;
    } vec_t;

    typedef struct {
        logic       caps;
        logic       letter;
        logic [4:0] idx;
        logic       shift;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [8:0] c, input logic m,
                       input logic ec, input logic el, input logic [4:0] ei, input logic es);
        vec_t t;
        t.valid = v; t.code = c; t.make = m;
        t.caps = ec; t.letter = el; t.idx = ei; t.shift = es;
        vecs.push_back(t);
    endtask

    // Drive one event, push its expectation, then compare one cycle later.
    task automatic step(input vec_t t);
        exp_t e, got;
        key_valid = t.valid;
        key_code  = t.code;
        key_make  = t.make;
        e.caps = t.caps; e.letter = t.letter; e.idx = t.idx; e.shift = t.shift;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            $display("txn %0d v=%0b code=%03h make=%0b -> caps=%0b let=%0b idx=%0d shift=%0b",
                     txn, t.valid, t.code, t.make, caps_valid, letter_valid, letter_idx, shift_held);
            chk($sformatf("caps_valid[%0d]", txn), int'(caps_valid), int'(got.caps));
            chk($sformatf("letter_valid[%0d]", txn), int'(letter_valid), int'(got.letter));
            chk($sformatf("letter_idx[%0d]", txn), int'(letter_idx), int'(got.idx));
            chk($sformatf("shift_held[%0d]", txn), int'(shift_held), int'(got.shift));
        end
        txn++;
    endtask

    task automatic step_ev(input logic v, input logic [8:0] c, input logic m,
                           input logic ec, input logic el, input logic [4:0] ei, input logic es);
        vec_t t;
        t.valid = v; t.code = c; t.make = m;
        t.caps = ec; t.letter = el; t.idx = ei; t.shift = es;
        step(t);
    endtask

    initial begin
        //   valid code    make caps let idx shift
        add(1, 9'h058, 1, 1, 0, 0,  0);   // caps press -> pulse
        add(0, 9'h058, 1, 0, 0, 0,  0);   // idle: pulse lasts one cycle
        add(1, 9'h058, 1, 0, 0, 0,  0);   // typematic repeats filtered
        add(1, 9'h058, 1, 0, 0, 0,  0);
        add(1, 9'h058, 1, 0, 0, 0,  0);
        add(1, 9'h058, 0, 0, 0, 0,  0);   // release
        add(1, 9'h058, 1, 1, 0, 0,  0);   // second press -> second pulse
        add(1, 9'h058, 0, 0, 0, 0,  0);
        add(1, 9'h058, 0, 0, 0, 0,  0);   // break in CAPS_UP ignored
        add(1, 9'h01C, 1, 0, 1, 0,  0);   // 'a'
        add(1, 9'h01C, 0, 0, 0, 0,  0);
        add(1, 9'h01A, 1, 0, 1, 25, 0);   // 'z'
        add(1, 9'h01A, 0, 0, 0, 25, 0);
        add(1, 9'h01C, 1, 0, 1, 0,  0);   // 'a' held with repeats
        add(1, 9'h01C, 1, 0, REP, 0, 0);
        add(1, 9'h01C, 1, 0, REP, 0, 0);
        add(1, 9'h01C, 0, 0, 0, 0,  0);
        add(1, 9'h032, 1, 0, 1, 1,  0);   // 'b'
        add(1, 9'h01C, 0, 0, 0, 1,  0);   // break of non-held letter ignored
        add(1, 9'h032, 1, 0, REP, 1, 0);  // still held -> repeat
        add(1, 9'h032, 0, 0, 0, 1,  0);
        add(1, 9'h03A, 1, 0, 1, 12, 0);   // 'm'
        add(1, 9'h03A, 0, 0, 0, 12, 0);
        add(1, 9'h012, 1, 0, 0, 12, 1);   // shift handling
        add(1, 9'h059, 1, 0, 0, 12, 1);
        add(1, 9'h012, 0, 0, 0, 12, 1);
        add(1, 9'h059, 0, 0, 0, 12, 0);
        add(1, 9'h158, 1, 0, 0, 12, 0);   // extended codes are neither caps nor letter
        add(1, 9'h11C, 1, 0, 0, 12, 0);
        add(1, 9'h058, 1, 1, 0, 12, 0);   // caps still UP after extended make
        add(1, 9'h058, 0, 0, 0, 12, 0);

        rst_n = 1'b0; key_valid = 1'b0; key_code = 9'h000; key_make = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_caps_valid",   int'(caps_valid),   0);
        chk("reset_letter_valid", int'(letter_valid), 0);
        chk("reset_letter_idx",   int'(letter_idx),   0);
        chk("reset_shift_held",   int'(shift_held),   0);
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Build up state, then assert reset between clock edges.
        step_ev(1, 9'h058, 1, 1, 0, 12, 0);   // caps now DOWN
        step_ev(1, 9'h012, 1, 0, 0, 12, 1);
        step_ev(1, 9'h01A, 1, 0, 1, 25, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_caps_valid",   int'(caps_valid),   0);
        chk("async_rst_letter_valid", int'(letter_valid), 0);
        chk("async_rst_letter_idx",   int'(letter_idx),   0);
        chk("async_rst_shift_held",   int'(shift_held),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Caps still physically down: typematic make after reset pulses once.
        step_ev(1, 9'h058, 1, 1, 0, 0, 0);
        step_ev(1, 9'h058, 1, 0, 0, 0, 0);
        step_ev(1, 9'h058, 0, 0, 0, 0, 0);
        // 'z' held across reset is forgotten, so a repeat counts as a new press.
        step_ev(1, 9'h01A, 1, 0, 1, 25, 0);
        step_ev(0, 9'h000, 0, 0, 0, 25, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
